// File: rtl/lector_pkg.sv
// -----------------------------------------------------------------------------
// lector_pkg
// Shared definitions for the coded-ticket reader:
//   - FSM state encoding (IDLE / CHECK / REPORT)
//   - verdict codes driven on V
//   - bit offsets of the fields packed into a code L = {id, mes, dia}
//   - date limits and the date sanity-check helper
// Optional feature macro used by the design files: LECTOR_DUP_CHECK_EN
// -----------------------------------------------------------------------------
package lector_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [1:0] V_NONE = 2'b00;
    localparam logic [1:0] V_OK   = 2'b01;
    localparam logic [1:0] V_EXP  = 2'b10;
    localparam logic [1:0] V_BAD  = 2'b11;

    localparam int DIA_LSB = 0;
    localparam int MES_LSB = 5;
    localparam int ID_LSB  = 9;

    localparam int MES_MAX = 12;
    localparam int DIA_MAX = 31;

    // True when the date fields cannot describe a real day/month.
    // Operands are widened by one bit so the upper-limit tests stay
    // meaningful even where the field width already caps the value.
    function automatic logic fecha_invalida(input logic [3:0] mes, input logic [4:0] dia);
        logic [4:0] mes_w;
        logic [5:0] dia_w;
        mes_w = {1'b0, mes};
        dia_w = {1'b0, dia};
        return (mes == 4'd0) || (mes_w > 5'(MES_MAX)) ||
               (dia == 5'd0) || (dia_w > 6'(DIA_MAX));
    endfunction

endpackage

// File: rtl/lector_historial.sv
// -----------------------------------------------------------------------------
// lector_historial
// Ring buffer of recently accepted ids with a parallel compare against a
// query id. Only compiled into the reader when LECTOR_DUP_CHECK_EN is defined.
// Ports:
//   CLK    in   1      clock, rising edge
//   CLR    in   1      asynchronous active-low reset, empties the history
//   push   in   1      store id_in at the write pointer
//   id_in  in   ID_W   id to store
//   id_q   in   ID_W   id being looked up
//   hit    out  1      id_q matches a filled entry (combinational)
// -----------------------------------------------------------------------------
module lector_historial #(
    parameter int ID_W  = 3,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            push,
    input  logic [ID_W-1:0] id_in,
    input  logic [ID_W-1:0] id_q,
    output logic            hit
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ID_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [DEPTH-1:0] match;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            // Oldest entry is overwritten once the ring wraps.
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            fill_d   = (fill_q == CNT_W'(DEPTH)) ? fill_q : fill_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            if (push) begin
                mem_q[wr_ptr_q] <= id_in;
            end
        end
    end

    // Entries fill from index 0 upwards, so "filled" is simply index < count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        assign match[gi] = (CNT_W'(gi) < fill_q) && (mem_q[gi] == id_q);
    end

    assign hit = |match;

endmodule

// File: rtl/lector_codigos_param.sv
// -----------------------------------------------------------------------------
// lector_codigos_param
// Checks a coded ticket L = {id, mes, dia} against a reference date, returns a
// verdict on V, counts accepted codes on P (saturating) and keeps the last
// accepted code on QR. One code is processed every three cycles:
// IDLE (capture) -> CHECK (evaluate) -> REPORT (V/DUP valid).
// Optional duplicate-id rejection is built when LECTOR_DUP_CHECK_EN is defined;
// otherwise DUP stays 0 and DEPTH only has to be a legal value.
// Ports:
//   CLK     in   1        clock, rising edge
//   CLR     in   1        asynchronous active-low reset
//   EN      in   1        code-present strobe (ignored while BUSY)
//   L       in   ID_W+9   code: [4:0] dia, [8:5] mes, [ID_W+8:9] id
//   diaRef  in   5        reference day
//   mesRef  in   4        reference month
//   P       out  P_W      accepted-code count, saturating
//   V       out  2        verdict, non-zero only in REPORT
//   QR      out  ID_W+9   last accepted code
//   BUSY    out  1        code in flight (CHECK or REPORT)
//   DUP     out  1        with V=11, rejection was a duplicate id
// -----------------------------------------------------------------------------
module lector_codigos_param
    import lector_pkg::*;
#(
    parameter int ID_W  = 3,
    parameter int P_W   = 4,
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              EN,
    input  logic [ID_W+8:0]   L,
    input  logic [4:0]        diaRef,
    input  logic [3:0]        mesRef,
    output logic [P_W-1:0]    P,
    output logic [1:0]        V,
    output logic [ID_W+8:0]   QR,
    output logic              BUSY,
    output logic              DUP
);

    localparam int CODE_W = ID_W + 9;

    if (DEPTH < 1) begin : g_bad_depth
        $error("lector_codigos_param: DEPTH must be >= 1");
    end

    state_t              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [4:0]          dia_ref_q, dia_ref_d;
    logic [3:0]          mes_ref_q, mes_ref_d;
    logic [1:0]          v_q, v_d;
    logic                dup_q, dup_d;
    logic [P_W-1:0]      p_q, p_d;
    logic [CODE_W-1:0]   qr_q, qr_d;

    logic [ID_W-1:0]     id_cap;
    logic [3:0]          mes_cap;
    logic [4:0]          dia_cap;
    logic                malformed;
    logic                expired;
    logic                dup_hit;
    logic [1:0]          verdict;
    logic                verdict_dup;

    assign id_cap  = code_q[CODE_W-1:ID_LSB];
    assign mes_cap = code_q[MES_LSB +: 4];
    assign dia_cap = code_q[DIA_LSB +: 5];

    assign malformed = fecha_invalida(mes_cap, dia_cap);
    // Month-major numeric compare; the reference date itself is not validated.
    assign expired   = {mes_cap, dia_cap} < {mes_ref_q, dia_ref_q};

`ifdef LECTOR_DUP_CHECK_EN
    logic hist_push;

    // Only accepted ids enter the history; the push lands on the same edge
    // that registers the verdict, well before the next code reaches CHECK.
    assign hist_push = (state_q == CHECK) && (verdict == V_OK);

    lector_historial #(
        .ID_W  (ID_W),
        .DEPTH (DEPTH)
    ) u_historial (
        .CLK   (CLK),
        .CLR   (CLR),
        .push  (hist_push),
        .id_in (id_cap),
        .id_q  (id_cap),
        .hit   (dup_hit)
    );
`else
    assign dup_hit = 1'b0;
`endif

    // Verdict priority: malformed, duplicate, expired, accepted.
    always_comb begin
        verdict     = V_OK;
        verdict_dup = 1'b0;
        if (malformed) begin
            verdict = V_BAD;
        end else if (dup_hit) begin
            verdict     = V_BAD;
            verdict_dup = 1'b1;
        end else if (expired) begin
            verdict = V_EXP;
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        dia_ref_d = dia_ref_q;
        mes_ref_d = mes_ref_q;
        v_d       = V_NONE;
        dup_d     = 1'b0;
        p_d       = p_q;
        qr_d      = qr_q;
        case (state_q)
            IDLE: begin
                if (EN) begin
                    code_d    = L;
                    dia_ref_d = diaRef;
                    mes_ref_d = mesRef;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                // Registering here makes V/DUP visible for exactly the REPORT cycle.
                v_d     = verdict;
                dup_d   = verdict_dup;
                state_d = REPORT;
                if (verdict == V_OK) begin
                    p_d  = (&p_q) ? p_q : p_q + P_W'(1);
                    qr_d = code_q;
                end
            end
            REPORT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= IDLE;
            code_q    <= '0;
            dia_ref_q <= '0;
            mes_ref_q <= '0;
            v_q       <= V_NONE;
            dup_q     <= 1'b0;
            p_q       <= '0;
            qr_q      <= '0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            dia_ref_q <= dia_ref_d;
            mes_ref_q <= mes_ref_d;
            v_q       <= v_d;
            dup_q     <= dup_d;
            p_q       <= p_d;
            qr_q      <= qr_d;
        end
    end

    assign P    = p_q;
    assign V    = v_q;
    assign QR   = qr_q;
    assign DUP  = dup_q;
    assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_lector_codigos_param.sv
module tb_lector_codigos_param;

    localparam int ID_W   = 3;
    localparam int P_W    = 2;
    localparam int DEPTH  = 4;
    localparam int CODE_W = ID_W + 9;
    localparam int NVEC   = 16;

    logic              CLK = 1'b0;
    logic              CLR = 1'b0;
    logic              EN = 1'b0;
    logic [CODE_W-1:0] L = '0;
    logic [4:0]        diaRef = 5'd10;
    logic [3:0]        mesRef = 4'd6;
    logic [P_W-1:0]    P;
    logic [1:0]        V;
    logic [CODE_W-1:0] QR;
    logic              BUSY;
    logic              DUP;

    lector_codigos_param #(
        .ID_W  (ID_W),
        .P_W   (P_W),
        .DEPTH (DEPTH)
    ) dut (
        .CLK    (CLK),
        .CLR    (CLR),
        .EN     (EN),
        .L      (L),
        .diaRef (diaRef),
        .mesRef (mesRef),
        .P      (P),
        .V      (V),
        .QR     (QR),
        .BUSY   (BUSY),
        .DUP    (DUP)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [1:0]        v;
        logic              dup;
    } vec_t;

    typedef struct {
        logic [1:0]        v;
        logic              dup;
        logic [P_W-1:0]    p;
        logic [CODE_W-1:0] qr;
        int                idx;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[NVEC];

    int n_tests = 0;
    int n_fail  = 0;

    logic [P_W-1:0]    exp_p  = '0;
    logic [CODE_W-1:0] exp_qr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected verdicts were worked out by hand for diaRef=10, mesRef=6,
    // DEPTH=4; v_on/dup_on apply with duplicate rejection built in.
    function automatic vec_t mk(input int id, input int mes, input int dia,
                                input logic [1:0] v_on, input logic dup_on,
                                input logic [1:0] v_off);
        vec_t r;
        r.code = {3'(id), 4'(mes), 5'(dia)};
`ifdef LECTOR_DUP_CHECK_EN
        r.v   = v_on;
        r.dup = dup_on;
`else
        r.v   = v_off;
        r.dup = 1'b0;
        if (dup_on) r.dup = 1'b0;
`endif
        return r;
    endfunction

    // One transaction: queue the expectation, present the code for one
    // capture, then keep EN high with a poisoned code/reference while BUSY.
    task automatic send(input int idx);
        vec_t vv;
        exp_t e;
        int   waitc;
        vv    = vecs[idx];
        waitc = 0;
        while (BUSY !== 1'b0 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        if (BUSY !== 1'b0) begin
            check("idle_wait_timeout", 32'(BUSY), 32'd0);
        end
        if (vv.v == 2'b01) begin
            exp_p  = (exp_p == 2'd3) ? exp_p : exp_p + 2'd1;
            exp_qr = vv.code;
        end
        e.v   = vv.v;
        e.dup = vv.dup;
        e.p   = exp_p;
        e.qr  = exp_qr;
        e.idx = idx;
        sb.push_back(e);
        $display("[TB] vec %0d: L=%03h expect V=%0b DUP=%0b P=%0d", idx, vv.code, vv.v, vv.dup, exp_p);
        L  = vv.code;
        EN = 1'b1;
        @(posedge CLK);
        #1;
        check("busy_after_capture", 32'(BUSY), 32'd1);
        L      = {3'd7, 4'd15, 5'd31};
        diaRef = 5'd31;
        mesRef = 4'd15;
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        EN     = 1'b0;
        L      = '0;
        diaRef = 5'd10;
        mesRef = 4'd6;
    endtask

    // Monitor: every non-zero verdict must match the oldest expectation;
    // counter and last-code outputs are checked on the following cycle.
    initial begin
        exp_t e;
        #1;
        forever begin
            @(negedge CLK);
            if (V !== 2'b00) begin
                if (sb.size() == 0) begin
                    check("unexpected_verdict", 32'(V), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("v[%0d]", e.idx), 32'(V), 32'(e.v));
                    check($sformatf("dup[%0d]", e.idx), 32'(DUP), 32'(e.dup));
                    @(negedge CLK);
                    check($sformatf("p[%0d]", e.idx), 32'(P), 32'(e.p));
                    check($sformatf("qr[%0d]", e.idx), 32'(QR), 32'(e.qr));
                    check($sformatf("v_cleared[%0d]", e.idx), 32'(V), 32'd0);
                end
            end
        end
    end

    initial begin
        int waitc;
        //             id mes dia  V(on)  DUP  V(off)
        vecs[0]  = mk(1,  6, 10, 2'b01, 1'b0, 2'b01); // equal date accepted
        vecs[1]  = mk(3,  7,  2, 2'b01, 1'b0, 2'b01);
        vecs[2]  = mk(2,  6,  9, 2'b10, 1'b0, 2'b10);
        vecs[3]  = mk(2,  5, 31, 2'b10, 1'b0, 2'b10);
        vecs[4]  = mk(4,  0, 15, 2'b11, 1'b0, 2'b11);
        vecs[5]  = mk(4, 13, 15, 2'b11, 1'b0, 2'b11);
        vecs[6]  = mk(4,  6,  0, 2'b11, 1'b0, 2'b11);
        vecs[7]  = mk(1,  6, 10, 2'b11, 1'b1, 2'b01); // duplicate of id 1
        vecs[8]  = mk(1,  0,  5, 2'b11, 1'b0, 2'b11); // malformed beats duplicate
        vecs[9]  = mk(2,  6, 11, 2'b01, 1'b0, 2'b01);
        vecs[10] = mk(4,  8,  1, 2'b01, 1'b0, 2'b01); // ring now full
        vecs[11] = mk(5, 12, 31, 2'b01, 1'b0, 2'b01); // wraps, evicts id 1
        vecs[12] = mk(3,  9,  9, 2'b11, 1'b1, 2'b01); // id 3 still held
        vecs[13] = mk(1,  6, 10, 2'b01, 1'b0, 2'b01); // id 1 aged out
        vecs[14] = mk(5,  6, 10, 2'b11, 1'b1, 2'b01);
        vecs[15] = mk(2,  1,  1, 2'b11, 1'b1, 2'b10); // duplicate beats expired

        repeat (3) @(negedge CLK);
        check("rst_p", 32'(P), 32'd0);
        check("rst_v", 32'(V), 32'd0);
        check("rst_qr", 32'(QR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_dup", 32'(DUP), 32'd0);
        CLR = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < NVEC; i++) begin
            send(i);
        end

        waitc = 0;
        while (sb.size() != 0 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        check("queue_drained", 32'(sb.size()), 32'd0);
        @(negedge CLK);

        // Reset while a code sits in CHECK: everything clears at once and
        // the in-flight code never produces a verdict.
        L  = {3'd6, 4'd6, 5'd10};
        EN = 1'b1;
        @(posedge CLK);
        #1;
        check("busy_before_midreset", 32'(BUSY), 32'd1);
        EN = 1'b0;
        #2;
        CLR = 1'b0;
        #1;
        check("midrst_p", 32'(P), 32'd0);
        check("midrst_v", 32'(V), 32'd0);
        check("midrst_qr", 32'(QR), 32'd0);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_dup", 32'(DUP), 32'd0);
        exp_p  = '0;
        exp_qr = '0;
        @(negedge CLK);
        CLR = 1'b1;
        repeat (4) @(negedge CLK);

        // History was emptied, so a previously accepted id passes again.
        vecs[0] = mk(5, 7, 7, 2'b01, 1'b0, 2'b01);
        send(0);
        waitc = 0;
        while (sb.size() != 0 && waitc < 20) begin
            @(negedge CLK);
            waitc++;
        end
        check("queue_drained_final", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
